// File: rtl/fp_addsub_unit.sv
// Multi-cycle parametrised floating-point adder/subtractor behind a start/done handshake (fixed 5-cycle latency).
// Rounding is truncation by default; define FP_ADDSUB_RNE_EN for round-to-nearest, ties-to-even.
module fp_addsub_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a1,
  input  logic [EXP_W+MAN_W:0] a2,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done,
  output logic                 busy,
  output logic [3:0]           flags
);

  localparam int FW     = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;          // significand with hidden bit
  localparam int EXT_W  = MAN_W + 4;          // significand plus guard/round/sticky
  localparam int SH_MAX = MAN_W + 3;
  localparam int LZ_W   = $clog2(EXT_W + 1);
  localparam int XE_W   = EXP_W + LZ_W + 2;   // signed working exponent, room for deep cancellation

  localparam logic [XE_W-1:0]        SH_MAX_X = XE_W'(SH_MAX);
  localparam logic signed [XE_W-1:0] EXP_SAT  = XE_W'((2 ** EXP_W) - 1);
  localparam logic [FW-1:0]          QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  typedef enum logic [1:0] {K_NUM, K_NAN, K_INF} kind_t;

  function automatic logic [LZ_W-1:0] lzc(input logic [EXT_W-1:0] v);
    lzc = LZ_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++)
      if (v[i]) lzc = LZ_W'(EXT_W - 1 - i);
  endfunction

  state_t                  state;
  logic [FW-1:0]           op_a, op_b;
  kind_t                   kind_q;
  logic                    spec_sign_q, sgn_l_q, sgn_s_q;
  logic [EXP_W-1:0]        exp_l_q, exp_s_q;
  logic [SIG_W-1:0]        sig_l_q, sig_s_q;
  logic [EXT_W-1:0]        ext_l_q, ext_s_q;
  logic [EXT_W:0]          sum_q;
  logic [EXT_W-1:0]        norm_q;
  logic                    zero_q;
  logic signed [XE_W-1:0]  exp_q;

  // ---------------- UNPACK: decode, flush denormals, order by magnitude
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  kind_t            kind_c;
  logic             spec_sign_c;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    ea          = op_a[FW-2:MAN_W];
    eb          = op_b[FW-2:MAN_W];
    fa          = op_a[MAN_W-1:0];
    fb          = op_b[MAN_W-1:0];
    a_zero      = (ea == '0);
    b_zero      = (eb == '0);
    a_nan       = (ea == '1) && (fa != '0);
    b_nan       = (eb == '1) && (fb != '0);
    a_inf       = (ea == '1) && (fa == '0);
    b_inf       = (eb == '1) && (fb == '0);
    sig_a       = a_zero ? '0 : {1'b1, fa};
    sig_b       = b_zero ? '0 : {1'b1, fb};
    a_ge_b      = {ea, sig_a} >= {eb, sig_b};
    kind_c      = K_NUM;
    spec_sign_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (op_a[FW-1] != op_b[FW-1]))) begin
      kind_c = K_NAN;
    end else if (a_inf || b_inf) begin
      kind_c      = K_INF;
      spec_sign_c = a_inf ? op_a[FW-1] : op_b[FW-1];
    end
  end

  // ---------------- ALIGN: shift smaller operand, shifted-out bits collapse into sticky
  logic [XE_W-1:0]  diff, shamt;
  logic [EXT_W-1:0] ext_s0, shifted, lost_mask, ext_s_c;

  always_comb begin
    diff      = XE_W'(exp_l_q) - XE_W'(exp_s_q);
    shamt     = (diff > SH_MAX_X) ? SH_MAX_X : diff;
    ext_s0    = {sig_s_q, 3'b000};
    shifted   = ext_s0 >> shamt;
    lost_mask = ~({EXT_W{1'b1}} << shamt);
    ext_s_c   = {shifted[EXT_W-1:1], shifted[0] | (|(ext_s0 & lost_mask))};
  end

  // ---------------- ADD: magnitudes are ordered, so subtraction never goes negative
  logic [EXT_W:0] sum_c;

  always_comb begin
    if (sgn_l_q != sgn_s_q) sum_c = {1'b0, ext_l_q} - {1'b0, ext_s_q};
    else                    sum_c = {1'b0, ext_l_q} + {1'b0, ext_s_q};
  end

  // ---------------- NORM: one-step right shift on carry, otherwise full left normalise
  logic [LZ_W-1:0]        lz;
  logic [EXT_W-1:0]       norm_c;
  logic signed [XE_W-1:0] exp_n_c;

  always_comb begin
    lz = lzc(sum_q[EXT_W-1:0]);
    if (sum_q[EXT_W]) begin
      norm_c  = {sum_q[EXT_W:2], sum_q[1] | sum_q[0]};
      exp_n_c = exp_q + XE_W'(1);
    end else begin
      norm_c  = sum_q[EXT_W-1:0] << lz;
      exp_n_c = exp_q - XE_W'(lz);
    end
  end

  // ---------------- ROUND and pack, specials resolved by priority
  logic [SIG_W-1:0]       mant;
  logic                   grd, rnd, stk, rnd_up, inexact;
  logic [SIG_W:0]         mant_r;
  logic [MAN_W-1:0]       frac_r;
  logic signed [XE_W-1:0] exp_r;
  logic [FW-1:0]          result_c;
  logic [3:0]             flags_c;

  always_comb begin
    mant    = norm_q[EXT_W-1:3];
    grd     = norm_q[2];
    rnd     = norm_q[1];
    stk     = norm_q[0];
    inexact = grd | rnd | stk;
`ifdef FP_ADDSUB_RNE_EN
    rnd_up  = grd & (rnd | stk | mant[0]);
`else
    rnd_up  = 1'b0;
`endif
    mant_r   = {1'b0, mant} + (SIG_W+1)'(rnd_up);
    frac_r   = mant_r[SIG_W] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    exp_r    = exp_q + XE_W'(mant_r[SIG_W]);
    result_c = {sgn_l_q, exp_r[EXP_W-1:0], frac_r};
    flags_c  = {3'b000, inexact};
    if (kind_q == K_NAN) begin
      result_c = QNAN;
      flags_c  = 4'b1000;
    end else if (kind_q == K_INF) begin
      result_c = {spec_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c  = 4'b0000;
    end else if (zero_q) begin
      // Cancellation yields +0; only two negative zeros keep the sign.
      result_c = {sgn_l_q & sgn_s_q, {(FW-1){1'b0}}};
      flags_c  = 4'b0000;
    end else if (!exp_r[XE_W-1] && (exp_r >= EXP_SAT)) begin
      result_c = {sgn_l_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c  = 4'b0101;
    end else if (exp_r[XE_W-1] || (exp_r == '0)) begin
      result_c = {sgn_l_q, {(FW-1){1'b0}}};
      flags_c  = 4'b0011;
    end
  end

  // ---------------- Sequencer and stage registers
  // NOTE: sequential state uses non-blocking assignments so every stage reads pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      result      <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      flags       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      kind_q      <= K_NUM;
      spec_sign_q <= 1'b0;
      sgn_l_q     <= 1'b0;
      sgn_s_q     <= 1'b0;
      exp_l_q     <= '0;
      exp_s_q     <= '0;
      sig_l_q     <= '0;
      sig_s_q     <= '0;
      ext_l_q     <= '0;
      ext_s_q     <= '0;
      sum_q       <= '0;
      norm_q      <= '0;
      zero_q      <= 1'b0;
      exp_q       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_a  <= a1;
            op_b  <= {a2[FW-1] ^ op, a2[FW-2:0]};
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          kind_q      <= kind_c;
          spec_sign_q <= spec_sign_c;
          if (a_ge_b) begin
            sgn_l_q <= op_a[FW-1]; exp_l_q <= ea; sig_l_q <= sig_a;
            sgn_s_q <= op_b[FW-1]; exp_s_q <= eb; sig_s_q <= sig_b;
          end else begin
            sgn_l_q <= op_b[FW-1]; exp_l_q <= eb; sig_l_q <= sig_b;
            sgn_s_q <= op_a[FW-1]; exp_s_q <= ea; sig_s_q <= sig_a;
          end
          state <= S_ALIGN;
        end
        S_ALIGN: begin
          ext_l_q <= {sig_l_q, 3'b000};
          ext_s_q <= ext_s_c;
          state   <= S_ADD;
        end
        S_ADD: begin
          sum_q <= sum_c;
          exp_q <= XE_W'(exp_l_q);
          state <= S_NORM;
        end
        S_NORM: begin
          norm_q <= norm_c;
          exp_q  <= exp_n_c;
          zero_q <= (sum_q == '0);
          state  <= S_ROUND;
        end
        S_ROUND: begin
          result <= result_c;
          flags  <= flags_c;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Self-checking bench for fp_addsub_unit: directed cases plus random operands against an exact-arithmetic model.
module tb_fp_addsub_unit;

`ifdef FP_ADDSUB_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a1 = '0;
  logic [31:0] a2 = '0;
  logic [31:0] result;
  logic        done, busy;
  logic [3:0]  flags;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_addsub_unit #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a1(a1), .a2(a2),
    .result(result), .done(done), .busy(busy), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact reference: operands become integers scaled by 2^-150, summed exactly, then rounded once.
  function automatic logic [35:0] ref_addsub(input logic [31:0] x, input logic [31:0] y, input logic o);
    logic         sx, sy, sr, up, inexact;
    int           ex, ey, p, e;
    logic [23:0]  mx, my;
    logic [299:0] ix, iy, mag, rem, half;
    logic [24:0]  m;
    sx = x[31];
    sy = y[31] ^ o;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) || (ex == 255 && ey == 255 && sx != sy))
      return {32'h7FC00000, 4'b1000};
    if (ex == 255) return {sx, 8'hFF, 23'd0, 4'b0000};
    if (ey == 255) return {sy, 8'hFF, 23'd0, 4'b0000};
    mx = (ex == 0) ? 24'd0 : {1'b1, x[22:0]};
    my = (ey == 0) ? 24'd0 : {1'b1, y[22:0]};
    ix = 300'(mx) << ex;
    iy = 300'(my) << ey;
    if (sx == sy)      begin mag = ix + iy; sr = sx; end
    else if (ix >= iy) begin mag = ix - iy; sr = sx; end
    else               begin mag = iy - ix; sr = sy; end
    if (mag == 0) return {sx & sy, 31'd0, 4'b0000};
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 23;
    if (p > 23) begin
      m       = 25'(mag >> (p - 23));
      rem     = mag & ((300'(1) << (p - 23)) - 300'(1));
      half    = 300'(1) << (p - 24);
      inexact = (rem != 0);
      up      = RNE && ((rem > half) || (rem == half && m[0]));
      m       = m + 25'(up);
      if (m[24]) begin m = m >> 1; e++; end
    end else begin
      m       = 25'(mag << (23 - p));
      inexact = 1'b0;
    end
    if (e >= 255) return {sr, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0)   return {sr, 31'd0, 4'b0011};
    return {sr, 8'(e), m[22:0], 3'b000, inexact};
  endfunction

  function automatic logic [31:0] gen_operand(input logic [7:0] near);
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0:       v[30:0]  = '0;
      1:       v[30:0]  = {8'hFF, 23'd0};
      2:       v[30:23] = 8'hFF;
      3:       v[30:23] = 8'h00;
      4:       v[30:23] = 8'hFE;
      5:       v[30:23] = 8'h01;
      6, 7:    v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = near + 8'($urandom_range(0, 8)) - 8'd4;
    endcase
    return v;
  endfunction

  // Issues one operation, scrambles the inputs after capture, and waits (bounded) for done.
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic o,
                        output logic [31:0] r, output logic [3:0] f);
    int n;
    @(negedge clk);
    a1 = x; a2 = y; op = o; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a1 = $urandom; a2 = $urandom; op = 1'($urandom);
    check({tag, "_busy_at_start"}, busy, 1'b1);
    check({tag, "_done_cleared"}, done, 1'b0);
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    r = result;
    f = flags;
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y, input logic o,
                          input logic [31:0] er, input logic [3:0] ef);
    logic [31:0] r;
    logic [3:0]  f;
    run_op(tag, x, y, o, r, f);
    check({tag, "_result"}, r, er);
    check({tag, "_flags"}, f, ef);
  endtask

  logic [31:0] rx, ry, rr;
  logic [3:0]  rf;
  logic        ro;
  logic [35:0] mref;
  int          nb, kind;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 32'h0);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_flags", flags, 4'h0);
    @(negedge clk);
    reset = 1'b1;

    directed("add_basic", 32'h3FE00000, 32'h40500000, 1'b0, 32'h40A00000, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", done, 1'b1);
    check("hold_result", result, 32'h40A00000);
    directed("sub_basic", 32'h3FE00000, 32'h40500000, 1'b1, 32'hBFC00000, 4'b0000);
    directed("add_sticky", 32'h43E42666, 32'h4140F5C3, 1'b0, 32'h43EA2E14, 4'b0001);
    directed("sub_sticky", 32'hC3E42666, 32'h4140F5C3, 1'b0, RNE ? 32'hC3DE1EB8 : 32'hC3DE1EB7, 4'b0001);
    directed("tie_even", 32'h3F800001, 32'h33800000, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 4'b0001);
    directed("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    directed("inf_plus_one", 32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000);
    directed("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    directed("cancel", 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 4'b0000);
    directed("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    directed("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);

    // Reset in the middle of an operation aborts it at once.
    @(negedge clk);
    a1 = 32'h3FE00000; a2 = 32'h40500000; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_flags", flags, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", busy, 1'b0);
    directed("reissue", 32'h3FE00000, 32'h40500000, 1'b0, 32'h40A00000, 4'b0000);

    // A start pulse while busy must not disturb the operation in flight.
    @(negedge clk);
    a1 = 32'h3FE00000; a2 = 32'h40500000; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nb = 0;
    while (!done && nb < 8) begin
      if (nb == 1) begin a1 = 32'h40400000; a2 = 32'h40400000; op = 1'b1; start = 1'b1; end
      if (nb == 3) start = 1'b0;
      @(posedge clk);
      #1;
      nb++;
    end
    check("busy_start_latency", nb, 5);
    check("busy_start_result", result, 32'h40A00000);
    check("busy_start_flags", flags, 4'h0);
    repeat (6) @(posedge clk);
    #1;
    check("busy_start_no_rerun_done", done, 1'b1);
    check("busy_start_no_rerun_result", result, 32'h40A00000);

    // Random back-to-back operations against the exact model.
    for (int i = 0; i < 300; i++) begin
      rx   = gen_operand(8'($urandom_range(1, 254)));
      kind = $urandom_range(0, 9);
      if (kind == 0)      ry = rx;
      else if (kind == 1) ry = rx ^ 32'($urandom_range(0, 7));
      else if (kind == 2) ry = {~rx[31], rx[30:0]};
      else                ry = gen_operand(rx[30:23]);
      ro   = 1'($urandom);
      mref = ref_addsub(rx, ry, ro);
      run_op("rand", rx, ry, ro, rr, rf);
      check("rand_result", rr, mref[35:4]);
      check("rand_flags", rf, mref[3:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
